// File: rtl/bcd_operand_aligner.sv
// rtl/bcd_operand_aligner.sv - decimal-point aligner for two packed-BCD operands ahead of the BCD adder

module bcd_right_shifter #(
    parameter int W = 16
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [3:0]   digit_out
);
    assign dout      = {4'b0000, din[W-1:4]};
    assign digit_out = din[3:0];
endmodule

module bcd_operand_aligner #(
    parameter int NUM_DIGITS = 4,
    parameter int FRAC_W     = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [NUM_DIGITS*4-1:0] i_a_num,
    input  logic [FRAC_W-1:0]       i_a_frac,
    input  logic [NUM_DIGITS*4-1:0] i_b_num,
    input  logic [FRAC_W-1:0]       i_b_frac,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic [NUM_DIGITS*4-1:0] o_a_num,
    output logic [NUM_DIGITS*4-1:0] o_b_num,
    output logic [FRAC_W-1:0]       o_frac,
    output logic [3:0]              o_guard,
    output logic                    o_sticky,
    output logic                    o_b_shifted
);
    localparam int W     = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(NUM_DIGITS + 2);
    localparam int DW    = (FRAC_W > CNT_W) ? FRAC_W : CNT_W;

    typedef enum logic {
        IDLE,
        ALIGN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               finish;
    logic               shift_en;
    logic [CNT_W-1:0]   cnt_q;

    logic               b_gt;
    logic [FRAC_W-1:0]  frac_diff;
    logic [DW-1:0]      diff_ext;
    logic [CNT_W-1:0]   d_load;
    logic [W-1:0]       shift_in;
    logic [W-1:0]       shift_out;
    logic [3:0]         digit_out;

    assign b_gt      = i_b_frac > i_a_frac;
    assign frac_diff = b_gt ? (i_b_frac - i_a_frac) : (i_a_frac - i_b_frac);
    assign diff_ext  = DW'(frac_diff);
    // Anything past NUM_DIGITS+1 shifts behaves identically, so saturate there.
    assign d_load    = (diff_ext > DW'(NUM_DIGITS + 1)) ? CNT_W'(NUM_DIGITS + 1)
                                                        : CNT_W'(diff_ext);

    assign shift_in = o_b_shifted ? o_b_num : o_a_num;

    bcd_right_shifter #(
        .W(W)
    ) u_shifter (
        .din      (shift_in),
        .dout     (shift_out),
        .digit_out(digit_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        finish   = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    accept  = 1'b1;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else begin
                    shift_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q       <= '0;
            o_busy      <= 1'b0;
            o_valid     <= 1'b0;
            o_a_num     <= '0;
            o_b_num     <= '0;
            o_frac      <= '0;
            o_guard     <= '0;
            o_sticky    <= 1'b0;
            o_b_shifted <= 1'b0;
        end else begin
            o_valid <= finish;
            if (accept) begin
                o_a_num     <= i_a_num;
                o_b_num     <= i_b_num;
                o_frac      <= b_gt ? i_a_frac : i_b_frac;
                o_b_shifted <= b_gt;
                cnt_q       <= d_load;
                o_guard     <= '0;
                o_sticky    <= 1'b0;
                o_busy      <= 1'b1;
            end else if (shift_en) begin
                if (o_b_shifted) begin
                    o_b_num <= shift_out;
                end else begin
                    o_a_num <= shift_out;
                end
                // The previous guard digit retires into sticky as the new one arrives.
                o_sticky <= o_sticky | (o_guard != 4'h0);
                o_guard  <= digit_out;
                cnt_q    <= cnt_q - 1'b1;
            end else if (finish) begin
                o_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bcd_operand_aligner.sv
// tb/tb_bcd_operand_aligner.sv - self-checking bench for bcd_operand_aligner

module tb_bcd_operand_aligner;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_a_num = '0;
    logic [2:0]  i_a_frac = '0;
    logic [15:0] i_b_num = '0;
    logic [2:0]  i_b_frac = '0;
    logic        o_busy;
    logic        o_valid;
    logic [15:0] o_a_num;
    logic [15:0] o_b_num;
    logic [2:0]  o_frac;
    logic [3:0]  o_guard;
    logic        o_sticky;
    logic        o_b_shifted;

    int total = 0;
    int bad   = 0;

    bcd_operand_aligner #(
        .NUM_DIGITS(4),
        .FRAC_W    (3)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_a_num    (i_a_num),
        .i_a_frac   (i_a_frac),
        .i_b_num    (i_b_num),
        .i_b_frac   (i_b_frac),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_a_num    (o_a_num),
        .o_b_num    (o_b_num),
        .o_frac     (o_frac),
        .o_guard    (o_guard),
        .o_sticky   (o_sticky),
        .o_b_shifted(o_b_shifted)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: alignment as division by powers of ten in nibble form,
    // guard is the lowest kept-out digit, sticky the OR of the rest.
    task automatic model(input logic [15:0] a, input int af, input logic [15:0] b, input int bf,
                         output logic [15:0] ea, output logic [15:0] eb, output int ef,
                         output int eg, output int es, output int ebs, output int ed);
        int m;
        int dig;
        ed  = (af > bf) ? af - bf : bf - af;
        if (ed > 5) ed = 5;
        ebs = (bf > af) ? 1 : 0;
        ef  = (af < bf) ? af : bf;
        m   = ebs ? int'(b) : int'(a);
        eg  = 0;
        es  = 0;
        for (int i = 0; i < ed; i++) begin
            dig = (i < 4) ? ((m >> (4 * i)) & 15) : 0;
            if (i == ed - 1) eg = dig;
            else if (dig != 0) es = 1;
        end
        m  = m >> (4 * ed);
        ea = ebs ? a : m[15:0];
        eb = ebs ? m[15:0] : b;
    endtask

    // Called with the clock low; returns at the falling edge of the o_valid cycle.
    task automatic run_op(input logic [15:0] a, input int af, input logic [15:0] b, input int bf,
                          input bit busy_start);
        logic [15:0] ea, eb;
        int ef, eg, es, ebs, ed, n;
        model(a, af, b, bf, ea, eb, ef, eg, es, ebs, ed);
        i_a_num  = a;
        i_a_frac = 3'(af);
        i_b_num  = b;
        i_b_frac = 3'(bf);
        i_start  = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        n = 0;
        i_start = busy_start;
        if (busy_start) begin
            i_a_num  = 16'h4321;
            i_a_frac = 3'd0;
            i_b_num  = 16'h8765;
            i_b_frac = 3'd6;
        end
        while (!o_valid && n < 20) begin
            chk("busy_during_align", o_busy, 1);
            @(negedge i_clk);
            i_start = 1'b0;
            n++;
        end
        i_start = 1'b0;
        chk("latency", n, ed + 1);
        chk("valid", o_valid, 1);
        chk("busy_at_valid", o_busy, 0);
        chk("a_num", o_a_num, ea);
        chk("b_num", o_b_num, eb);
        chk("frac", o_frac, ef);
        chk("guard", o_guard, eg);
        chk("sticky", o_sticky, es);
        chk("b_shifted", o_b_shifted, ebs);
    endtask

    initial begin
        logic [15:0] hold_b;
        int          seen;

        repeat (2) @(negedge i_clk);
        chk("reset_outputs", {o_busy, o_valid, o_a_num, o_b_num, o_frac, o_guard, o_sticky, o_b_shifted}, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Basic B shift, with a start pulsed while busy
        run_op(16'h1234, 1, 16'h0567, 3, 1'b1);
        chk("basic_a", o_a_num, 16'h1234);
        chk("basic_b", o_b_num, 16'h0005);
        chk("basic_guard", o_guard, 6);
        chk("basic_sticky", o_sticky, 1);
        hold_b = o_b_num;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            if (o_valid || o_busy) seen++;
        end
        chk("no_second_valid", seen, 0);
        chk("hold_b", o_b_num, hold_b);

        // Tie
        run_op(16'h9876, 2, 16'h0100, 2, 1'b0);
        chk("tie_a", o_a_num, 16'h9876);
        chk("tie_b", o_b_num, 16'h0100);
        chk("tie_bs", o_b_shifted, 0);

        // A shift with zero sticky, presented back-to-back in the valid cycle
        run_op(16'h1500, 3, 16'h0042, 1, 1'b0);
        chk("ashift_a", o_a_num, 16'h0015);
        chk("ashift_guard", o_guard, 0);
        chk("ashift_sticky", o_sticky, 0);

        // Clamp
        run_op(16'h1000, 7, 16'h9999, 0, 1'b0);
        chk("clamp_a", o_a_num, 16'h0000);
        chk("clamp_b", o_b_num, 16'h9999);
        chk("clamp_sticky", o_sticky, 1);
        @(negedge i_clk);

        // Reset in the middle of the clamp alignment
        i_a_num = 16'h1000; i_a_frac = 3'd7; i_b_num = 16'h9999; i_b_frac = 3'd0;
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (2) @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("midreset_outputs", {o_busy, o_valid, o_a_num, o_b_num, o_frac, o_guard, o_sticky, o_b_shifted}, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        chk("midreset_no_valid", seen, 0);
        run_op(16'h9876, 2, 16'h0100, 2, 1'b0);

        // Random operands, including non-BCD nibbles and over-range differences
        for (int k = 0; k < 40; k++) begin
            run_op(16'($urandom), int'($urandom_range(0, 7)), 16'($urandom),
                   int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) @(negedge i_clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_operand_aligner.md
# bcd_operand_aligner

Multi-cycle decimal-point aligner placed directly upstream of the BCD add/subtract datapath. It takes two packed-BCD operands, each with its own count of fractional digits. It right-shifts the operand with more fractional digits one digit per clock through a one-digit `bcd_right_shifter` instance, until both operands share the smaller fractional count. It returns the aligned mantissas plus guard and sticky information for rounding.

## Interface
- `NUM_DIGITS`, 4, BCD digits per mantissa.
- `FRAC_W`, 3, width of fractional-digit counts (values 0..2^FRAC_W-1).
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_a_num`  in  NUM_DIGITS*4  operand A mantissa, packed BCD, MSD in top nibble.
- `i_a_frac`  in  FRAC_W  fractional digits of A.
- `i_b_num`  in  NUM_DIGITS*4  operand B mantissa.
- `i_b_frac`  in  FRAC_W  fractional digits of B.
- `o_busy`  out  1  high while an alignment is in progress.
- `o_valid`  out  1  one-cycle pulse; results are valid in this cycle.
- `o_a_num`  out  NUM_DIGITS*4  aligned A.
- `o_b_num`  out  NUM_DIGITS*4  aligned B.
- `o_frac`  out  FRAC_W  common fractional count, min(i_a_frac, i_b_frac).
- `o_guard`  out  4  last digit shifted out of the shifted operand (0 if no shift).
- `o_sticky`  out  1  OR of "nibble != 0" over all shifted-out digits except the guard.
- `o_b_shifted`  out  1  1 = B was shifted; 0 = A was shifted, or no shift.

## Operation
- States: IDLE, ALIGN.
- IDLE + `i_start`=1 at an edge:
  - Register both mantissas, and set `o_frac` = min of the two fractional counts.
  - Select the operand with the larger fractional count. On a tie, no shift and `o_b_shifted`=0.
  - Load counter with d = |i_a_frac − i_b_frac|, clamped to NUM_DIGITS+1.
  - Clear guard and sticky. Set `o_busy`=1. Go to ALIGN.
- ALIGN, each edge with counter ≠ 0:
  - Shift the selected mantissa right one digit, filling 0 at the MSD.
  - Set sticky |= (guard ≠ 0), then guard = digit shifted out.
  - Decrement the counter.
- ALIGN, edge with counter = 0: pulse `o_valid`=1 for one cycle, set `o_busy`=0, go to IDLE.
- The clamp makes over-range differences equivalent to shifting NUM_DIGITS+1 digits. The mantissa becomes 0, guard becomes 0, and sticky collects every original nonzero digit.
- Width of the counter: enough to hold NUM_DIGITS+1.
- Non-BCD nibbles (A–F) are shifted unchanged. Any nonzero nibble counts toward sticky.
- Unselected operand passes through unchanged.
- Result outputs hold their values from the `o_valid` cycle until the next accepted `i_start`.
- `i_start` while `o_busy`=1 is ignored. It does not queue and does not disturb the operation in progress.
- Operand inputs are only sampled on the accepting edge; they may change afterwards.

## Timing
- Reset (async assert, any state) forces IDLE. All outputs go to 0: `o_busy`, `o_valid`, `o_a_num`, `o_b_num`, `o_frac`, `o_guard`, `o_sticky`, `o_b_shifted`.
- Reset mid-ALIGN aborts with no `o_valid`. The first start after reset release is accepted normally.
- Latency: start accepted at edge E0. `o_valid` rises at edge E0+d+1, where d is the clamped difference. `o_busy` is high from E0 to E0+d+1.
- Throughput: a new `i_start` may be presented in the `o_valid` cycle. It is accepted at E0+d+2.
- d = 0 gives `o_valid` at E0+1 with the operands unchanged, guard 0 and sticky 0.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Basic shift of B: A=0x1234/frac1, B=0x0567/frac3, start. Required: B shifted two digits; `o_valid` at E0+3; A=0x1234, B=0x0005, frac=1, guard=6, sticky=1, `o_b_shifted`=1; `o_busy` high 3 cycles.
- Tie: A=0x9876/frac2, B=0x0100/frac2. Required: `o_valid` at E0+1, outputs equal inputs, frac=2, guard=0, sticky=0, `o_b_shifted`=0.
- Shift of A with zero sticky: A=0x1500/frac3, B=0x0042/frac1. Required: A=0x0015, guard=0, sticky=0, frac=1, `o_b_shifted`=0, `o_valid` at E0+3.
- Clamp: A=0x1000/frac7, B=0x9999/frac0. Required: d clamped to 5; `o_valid` at E0+6; A=0x0000, guard=0, sticky=1, B=0x9999, frac=0.
- Busy start ignored: pulse `i_start` with new operands at E0+1 during the basic case. Required: first result unaffected. No second `o_valid` unless start is re-asserted in IDLE.
- Mid-operation reset: assert `i_rst` asynchronously between edges during ALIGN of the clamp case. Required: all outputs 0 immediately and no `o_valid`. After release, the tie case completes correctly.
